// File: rtl/mastermind_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mastermind_ctrl
//  Purpose  : 4-peg / 8-colour code-breaking game controller with input
//             conditioning, code storage, try counting and 8-clock scoring.
//  Revision : 1.0  initial release
// ============================================================================
module mastermind_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int MAX_TRIES  = 10
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Btn1,
    input  logic       Btn2,
    input  logic       Btn3,
    input  logic       Btn4,
    input  logic       setVal,
    input  logic       Test,
    output logic [2:0] L1,
    output logic [2:0] L2,
    output logic [2:0] L3,
    output logic [2:0] L4,
    output logic [2:0] Red,
    output logic [2:0] White,
    output logic [3:0] tries_left,
    output logic [2:0] phase,
    output logic       win,
    output logic       lose
);

    localparam int                 c_CNT_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [3:0]         c_MAX_TRIES = 4'(MAX_TRIES);
    localparam int                 c_N_IN      = 6;

    typedef enum logic [2:0] {
        ST_SET   = 3'd0,
        ST_GUESS = 3'd1,
        ST_SCORE = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Bit order: Btn1..Btn4 at 0..3, setVal at 4, Test at 5
    logic [c_N_IN-1:0] w_raw;
    logic [c_N_IN-1:0] w_pulse;

    assign w_raw = {Test, setVal, Btn4, Btn3, Btn2, Btn1};

    for (genvar gi = 0; gi < c_N_IN; gi++) begin : g_cond
        logic               r_sync1_q, r_sync2_q, r_stable_q, r_pulse_q;
        logic               w_sync1_d, w_sync2_d, w_stable_d, w_pulse_d;
        logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;

        always_comb begin
            w_sync1_d  = w_raw[gi];
            w_sync2_d  = r_sync1_q;
            w_stable_d = r_stable_q;
            w_pulse_d  = 1'b0;
            w_cnt_d    = '0;
            // Counter runs only while the synced level disagrees with the stable one
            if (r_sync2_q != r_stable_q) begin
                if (r_cnt_q == c_DEB_LAST) begin
                    w_stable_d = r_sync2_q;
                    w_pulse_d  = r_sync2_q;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (Reset) begin
                r_sync1_q  <= 1'b0;
                r_sync2_q  <= 1'b0;
                r_stable_q <= 1'b0;
                r_pulse_q  <= 1'b0;
                r_cnt_q    <= '0;
            end else begin
                r_sync1_q  <= w_sync1_d;
                r_sync2_q  <= w_sync2_d;
                r_stable_q <= w_stable_d;
                r_pulse_q  <= w_pulse_d;
                r_cnt_q    <= w_cnt_d;
            end
        end

        assign w_pulse[gi] = r_pulse_q;
    end

    function automatic logic [2:0] f_count(input logic [3:0][2:0] v, input logic [2:0] c);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] == c) n = n + 3'd1;
        end
        return n;
    endfunction

    state_t           r_state_q, w_state_d;
    logic [3:0][2:0]  r_peg_q, w_peg_d, w_btn_peg;
    logic [3:0][2:0]  r_code_q, w_code_d;
    logic [3:0][2:0]  r_guess_q, w_guess_d;
    logic [2:0]       r_red_q, w_red_d;
    logic [2:0]       r_white_q, w_white_d;
    logic [3:0]       r_tries_q, w_tries_d;
    logic [2:0]       r_cidx_q, w_cidx_d;
    logic [2:0]       r_total_q, w_total_d;

    logic [2:0] w_cnt_code, w_cnt_guess, w_min, w_total_fin, w_exact;

    always_comb begin
        w_cnt_code  = f_count(r_code_q, r_cidx_q);
        w_cnt_guess = f_count(r_guess_q, r_cidx_q);
        w_min       = (w_cnt_code < w_cnt_guess) ? w_cnt_code : w_cnt_guess;
        w_total_fin = r_total_q + w_min;
        w_exact     = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_guess_q[i] == r_code_q[i]) w_exact = w_exact + 3'd1;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_peg_d   = r_peg_q;
        w_code_d  = r_code_q;
        w_guess_d = r_guess_q;
        w_red_d   = r_red_q;
        w_white_d = r_white_q;
        w_tries_d = r_tries_q;
        w_cidx_d  = r_cidx_q;
        w_total_d = r_total_q;
        w_btn_peg = r_peg_q;
        for (int i = 0; i < 4; i++) begin
            if (w_pulse[i]) w_btn_peg[i] = r_peg_q[i] + 3'd1;
        end

        case (r_state_q)
            ST_SET: begin
                if (w_pulse[4]) begin
                    w_code_d  = r_peg_q;
                    w_peg_d   = '0;
                    w_red_d   = '0;
                    w_white_d = '0;
                    w_tries_d = c_MAX_TRIES;
                    w_state_d = ST_GUESS;
                end else begin
                    w_peg_d = w_btn_peg;
                end
            end
            ST_GUESS: begin
                if (w_pulse[5]) begin
                    w_guess_d = r_peg_q;
                    w_tries_d = r_tries_q - 4'd1;
                    w_cidx_d  = '0;
                    w_total_d = '0;
                    w_state_d = ST_SCORE;
                end else begin
                    w_peg_d = w_btn_peg;
                end
            end
            ST_SCORE: begin
                w_total_d = w_total_fin;
                w_cidx_d  = r_cidx_q + 3'd1;
                if (r_cidx_q == 3'd7) begin
                    w_red_d   = w_exact;
                    w_white_d = w_total_fin - w_exact;
                    if (w_exact == 3'd4) begin
                        w_state_d = ST_WIN;
                    end else if (r_tries_q == 4'd0) begin
                        w_state_d = ST_LOSE;
                        w_peg_d   = r_code_q;
                    end else begin
                        w_state_d = ST_GUESS;
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                // New game keeps the stored code until the next store
                if (w_pulse[4]) begin
                    w_peg_d   = '0;
                    w_red_d   = '0;
                    w_white_d = '0;
                    w_tries_d = c_MAX_TRIES;
                    w_state_d = ST_SET;
                end
            end
            default: w_state_d = ST_SET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state_q <= ST_SET;
            r_peg_q   <= '0;
            r_code_q  <= '0;
            r_guess_q <= '0;
            r_red_q   <= '0;
            r_white_q <= '0;
            r_tries_q <= c_MAX_TRIES;
            r_cidx_q  <= '0;
            r_total_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_peg_q   <= w_peg_d;
            r_code_q  <= w_code_d;
            r_guess_q <= w_guess_d;
            r_red_q   <= w_red_d;
            r_white_q <= w_white_d;
            r_tries_q <= w_tries_d;
            r_cidx_q  <= w_cidx_d;
            r_total_q <= w_total_d;
        end
    end

    assign L1         = r_peg_q[0];
    assign L2         = r_peg_q[1];
    assign L3         = r_peg_q[2];
    assign L4         = r_peg_q[3];
    assign Red        = r_red_q;
    assign White      = r_white_q;
    assign tries_left = r_tries_q;
    assign phase      = r_state_q;
    assign win        = (r_state_q == ST_WIN);
    assign lose       = (r_state_q == ST_LOSE);

endmodule
`default_nettype wire
